capture_pack: RTL and testbench
===============================

Name: capture_pack

Overview:
- Parametrised successor to the fixed 8-lane DDR capture: packs per-edge ADC samples into wide write words for the capture buffer.
- Adds arm/trigger/length control, selectable word order, non-overlapping packing, write-full back-pressure and overflow reporting.
- Sits after the per-lane IDDR stage (rising/falling data already registered on dco) and feeds the capture buffer write port, all in the dco domain.

Parameters:
- DW, 8, bits per edge (lane count); one sample word = 2*DW bits.
- SAMPLES, 4, sample words per output word; wr_data width = SAMPLES*2*DW.
- LW, 16, width of the capture-length field.

Ports:
- dco  in  1  sample clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- dr  in  DW  rising-edge data from the IDDR stage.
- df  in  DW  falling-edge data from the IDDR stage.
- swap  in  1  word order: 0 = {dr, df of previous edge}; 1 = {df, dr} of the same edge.
- arm  in  1  one-cycle pulse; starts a new capture.
- trig_mode  in  1  0 = start immediately on arm; 1 = wait for trig.
- trig  in  1  external trigger, level-sampled.
- abort  in  1  return to IDLE from any state.
- len  in  LW  number of output words per capture; 0 = continuous until abort.
- wr_full  in  1  capture buffer full.
- wr_data  out  SAMPLES*2*DW  packed word; oldest sample in the MSBs, newest in the LSBs.
- wr_en  out  1  one-cycle write strobe.
- busy  out  1  state is ARMED or CAPT.
- done  out  1  state is DONE.
- ovf  out  1  sticky: a word was dropped because wr_full was high.

Behaviour:
- Reset: state IDLE; wr_data=0, wr_en=0, ovf=0, df_q=0; slot and word counters 0.
- df_q is df registered every edge, regardless of state.
- Sample word sw: swap=0 gives {dr, df_q}; swap=1 gives {df, dr}.
- FSM states: IDLE, ARMED, CAPT, DONE.
  - IDLE or DONE, arm=1: go to CAPT if trig_mode=0, else ARMED. Clear ovf, slot counter and word counter.
  - ARMED, trig=1: go to CAPT. The first accepted sample is the one on the edge after the trig edge.
  - CAPT, word counter reaches len (len≠0) on a word emit: go to DONE on the same edge.
  - abort=1 in any state: go to IDLE next edge. The partial word is discarded; no wr_en is issued. abort has priority over arm.
  - arm during ARMED or CAPT is ignored.
- Packing:
  - sw is accepted on every edge where the registered state is CAPT.
  - Accepted sw shifts into the packer LSB end; the slot counter increments.
  - On the edge accepting the SAMPLES-th sample: wr_data loads the full packed word, wr_en=1 for one cycle, slot counter wraps to 0.
  - Latency: first sample to wr_en is SAMPLES cycles.
- Back-pressure: if wr_full=1 on an emit edge, wr_en stays 0, ovf sets, and the word counter still increments. The capture window is time-bounded.
- Word counter is LW bits. When len=0 it wraps silently and never ends the capture.
- wr_data holds its last value between strobes.

Optional Feature:
- Macro: CAPTURE_PACK_TESTPAT_EN.
- Defined:
  - Adds input tp_en (1 bit).
  - When tp_en=1, sw is replaced by a 2*DW-bit ramp. The ramp resets to 0 on the arm pulse and increments once per accepted sample.
  - swap is ignored while tp_en=1.
- Undefined: no tp_en port; sw always comes from dr/df.

Test Plan:
- DW=8, SAMPLES=4, swap=0, trig_mode=0, len=2. Drive dr=0x10+n, df=0x80+n on edge n; arm.
  -> Two wr_en pulses 4 cycles apart, each word's 4 samples = {dr(k), df(k-1)} oldest first; then done=1, busy=0.
- swap=1, same stimulus.
  -> Each 16-bit sample = {df(k), dr(k)}; first word MSB sample = {df, dr} of the first accepted edge.
- trig_mode=1, arm, then trig high 10 cycles later.
  -> busy=1 and wr_en=0 until trig; first wr_en 4 cycles after the edge following trig.
- len=0, capture 3 words, wr_full=1 during the 2nd emit.
  -> Words 1 and 3 written, word 2 dropped, ovf=1. ovf clears on the next arm.
- abort after 2 accepted samples of a word.
  -> No wr_en; state IDLE next edge. A re-arm produces a word containing only new samples.
- rst_n low mid-CAPT (asynchronous, between edges).
  -> wr_en, busy, done, ovf and wr_data go to 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/capture_pack_if.sv
// capture_pack_if: write port between the sample packer and the capture buffer.
// The packer drives data and strobe; the buffer answers with its full flag.
interface capture_pack_if #(
    parameter int WW = 64
);
    logic [WW-1:0] wr_data;
    logic          wr_en;
    logic          wr_full;

    modport master (
        output wr_data,
        output wr_en,
        input  wr_full
    );

    modport slave (
        input  wr_data,
        input  wr_en,
        output wr_full
    );
endinterface

// File: rtl/capture_pack.sv
// capture_pack: packs per-edge DDR ADC samples into wide capture-buffer words.
// Optional ramp test-pattern source (tp_en input) when CAPTURE_PACK_TESTPAT_EN is defined.
module capture_pack #(
    parameter int DW      = 8,
    parameter int SAMPLES = 4,
    parameter int LW      = 16
) (
    input  logic          dco,
    input  logic          rst_n,
    input  logic [DW-1:0] dr,
    input  logic [DW-1:0] df,
    input  logic          swap,
    input  logic          arm,
    input  logic          trig_mode,
    input  logic          trig,
    input  logic          abort,
    input  logic [LW-1:0] len,
`ifdef CAPTURE_PACK_TESTPAT_EN
    input  logic          tp_en,
`endif
    output logic          busy,
    output logic          done,
    output logic          ovf,
    capture_pack_if.master wr
);
    localparam int SW = 2 * DW;
    localparam int WW = SAMPLES * SW;
    localparam int CW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           start;
    logic           accept;
    logic           emit;
    logic [DW-1:0]  df_q;
    logic [CW-1:0]  slot;
    logic [LW-1:0]  wcnt;
    logic [WW-1:0]  pack;
    logic [WW+SW-1:0] shifted;
    logic [WW-1:0]  pack_nxt;
    logic [SW-1:0]  sw;

`ifdef CAPTURE_PACK_TESTPAT_EN
    logic [SW-1:0] ramp;

    always_comb begin
        sw = swap ? {df, dr} : {dr, df_q};
        if (tp_en) sw = ramp;
    end

    always_ff @(posedge dco or negedge rst_n) begin
        if (!rst_n) ramp <= '0;
        else if (start) ramp <= '0;
        else if (accept) ramp <= ramp + SW'(1);
    end
`else
    always_comb begin
        sw = swap ? {df, dr} : {dr, df_q};
    end
`endif

    // Oldest sample drifts toward the MSBs as new ones enter at the LSBs.
    assign shifted  = {pack, sw};
    assign pack_nxt = shifted[WW-1:0];

    assign busy = (state == ARMED) || (state == CAPT);
    assign done = (state == DONE);

    always_ff @(posedge dco or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        accept    = 1'b0;
        emit      = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        start     = 1'b1;
                        state_nxt = trig_mode ? ARMED : CAPT;
                    end
                end
                ARMED: begin
                    if (trig) state_nxt = CAPT;
                end
                CAPT: begin
                    accept = 1'b1;
                    emit   = (slot == SLOT_LAST);
                    if (emit && len != '0 && (wcnt + LW'(1)) == len)
                        state_nxt = DONE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge dco or negedge rst_n) begin
        if (!rst_n) begin
            df_q       <= '0;
            pack       <= '0;
            slot       <= '0;
            wcnt       <= '0;
            ovf        <= 1'b0;
            wr.wr_data <= '0;
            wr.wr_en   <= 1'b0;
        end else begin
            df_q     <= df;
            wr.wr_en <= 1'b0;
            if (start) begin
                slot <= '0;
                wcnt <= '0;
                ovf  <= 1'b0;
            end else if (abort) begin
                slot <= '0;
            end else if (accept) begin
                pack <= pack_nxt;
                if (emit) begin
                    slot <= '0;
                    // A dropped word still consumes its slot in the window.
                    wcnt <= wcnt + LW'(1);
                    if (wr.wr_full) begin
                        ovf <= 1'b1;
                    end else begin
                        wr.wr_data <= pack_nxt;
                        wr.wr_en   <= 1'b1;
                    end
                end else begin
                    slot <= slot + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_capture_pack.sv
// tb_capture_pack: scoreboard bench for capture_pack with a sample-list reference model.
// Directed test-plan scenarios followed by randomized control and data traffic.
module tb_capture_pack;
    localparam int DW = 8;
    localparam int SAMPLES = 4;
    localparam int LW = 16;
    localparam int WW = SAMPLES * 2 * DW;

    logic          dco = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] dr = '0;
    logic [DW-1:0] df = '0;
    logic          swap = 1'b0;
    logic          arm = 1'b0;
    logic          trig_mode = 1'b0;
    logic          trig = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic          ovf;

    capture_pack_if #(.WW(WW)) wr_bus ();

    capture_pack #(.DW(DW), .SAMPLES(SAMPLES), .LW(LW)) dut (
        .dco       (dco),
        .rst_n     (rst_n),
        .dr        (dr),
        .df        (df),
        .swap      (swap),
        .arm       (arm),
        .trig_mode (trig_mode),
        .trig      (trig),
        .abort     (abort),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .wr        (wr_bus)
    );

    always #5 dco = ~dco;

    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [WW-1:0] got, logic [WW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Data source: fixed pattern for the directed scenarios, random afterwards.
    bit pat = 1'b1;
    int n = 0;
    always @(posedge dco) begin
        #1;
        n++;
        if (pat) begin
            dr = 8'(8'h10 + n);
            df = 8'(8'h80 + n);
        end else begin
            dr = 8'($urandom);
            df = 8'($urandom);
        end
    end

    // Reference model: a list of collected samples per capture.
    typedef enum {M_IDLE, M_WAIT, M_RUN, M_END} mode_t;
    mode_t          m_mode = M_IDLE;
    logic [2*DW-1:0] m_pend[$];
    logic [WW-1:0]  exp_q[$];
    logic [DW-1:0]  m_prev_df = '0;
    int             m_words = 0;
    bit             m_ovf = 1'b0;
    bit             m_wr = 1'b0;

    always @(posedge dco or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_pend.delete();
            m_prev_df = '0;
            m_words = 0;
            m_ovf = 1'b0;
            m_wr = 1'b0;
        end else begin
            logic [2*DW-1:0] s;
            logic [WW-1:0] word;
            s = swap ? {df, dr} : {dr, m_prev_df};
            m_wr = 1'b0;
            if (abort) begin
                m_mode = M_IDLE;
                m_pend.delete();
            end else begin
                case (m_mode)
                    M_IDLE, M_END: if (arm) begin
                        m_mode = trig_mode ? M_WAIT : M_RUN;
                        m_pend.delete();
                        m_words = 0;
                        m_ovf = 1'b0;
                    end
                    M_WAIT: if (trig) m_mode = M_RUN;
                    M_RUN: begin
                        m_pend.push_back(s);
                        if (m_pend.size() == SAMPLES) begin
                            word = '0;
                            foreach (m_pend[i]) word = (word << (2 * DW)) | WW'(m_pend[i]);
                            m_pend.delete();
                            m_words++;
                            if (wr_bus.wr_full) m_ovf = 1'b1;
                            else begin
                                exp_q.push_back(word);
                                m_wr = 1'b1;
                            end
                            if (len != 0 && m_words == int'(len)) m_mode = M_END;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
            m_prev_df = df;
        end
    end

    // Monitor: per-cycle status check plus scoreboard pop on every write.
    always @(negedge dco) begin
        logic [WW-1:0] w;
        chk("wr_en", WW'(wr_bus.wr_en), WW'(m_wr));
        chk("busy_done_ovf", WW'({busy, done, ovf}),
            WW'({(m_mode == M_WAIT || m_mode == M_RUN), (m_mode == M_END), m_ovf}));
        if (wr_bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", wr_bus.wr_data, 'x);
            end else begin
                w = exp_q.pop_front();
                chk("wr_data", wr_bus.wr_data, w);
            end
        end
    end

    task automatic step();
        @(posedge dco);
        #1;
    endtask

    task automatic pulse_arm();
        step();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("wait_done", WW'(done), WW'(1));
    endtask

    initial begin
        wr_bus.wr_full = 1'b0;
        #3;
        chk("rst_data", wr_bus.wr_data, '0);
        chk("rst_flags", WW'({wr_bus.wr_en, busy, done, ovf}), '0);
        #9 rst_n = 1'b1;
        step();

        // Plain order, two words
        swap = 1'b0; trig_mode = 1'b0; len = 16'd2;
        pulse_arm();
        wait_done(40);
        chk("t1_busy", WW'(busy), '0);

        // Swapped order
        swap = 1'b1;
        pulse_arm();
        wait_done(40);

        // Triggered start after a 10-cycle wait
        swap = 1'b0; trig_mode = 1'b1; len = 16'd1;
        pulse_arm();
        repeat (10) step();
        chk("t3_armed_busy", WW'(busy), WW'(1));
        trig = 1'b1;
        step();
        trig = 1'b0;
        wait_done(40);

        // Continuous capture, second word hits a full buffer
        trig_mode = 1'b0; len = 16'd0;
        pulse_arm();
        repeat (5) step();
        wr_bus.wr_full = 1'b1;
        repeat (4) step();
        wr_bus.wr_full = 1'b0;
        repeat (6) step();
        chk("t4_ovf", WW'(ovf), WW'(1));
        abort = 1'b1;
        step();
        abort = 1'b0;
        len = 16'd1;
        pulse_arm();
        chk("t4_ovf_clr", WW'(ovf), '0);
        wait_done(40);

        // Abort mid-word, then re-arm
        pulse_arm();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_idle", WW'({busy, done}), '0);
        pulse_arm();
        wait_done(40);

        // Asynchronous reset mid-capture
        len = 16'd0;
        pulse_arm();
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_data", wr_bus.wr_data, '0);
        chk("t6_flags", WW'({wr_bus.wr_en, busy, done, ovf}), '0);
        #8 rst_n = 1'b1;
        step();
        step();
        chk("t6_idle", WW'({busy, done}), '0);

        // Randomized traffic
        pat = 1'b0;
        for (int it = 0; it < 40; it++) begin
            swap = 1'($urandom);
            trig_mode = 1'($urandom);
            len = 16'($urandom_range(0, 3));
            pulse_arm();
            for (int c = 0; c < 40; c++) begin
                wr_bus.wr_full = ($urandom_range(0, 4) == 0);
                trig = ($urandom_range(0, 3) == 0);
                abort = ($urandom_range(0, 39) == 0);
                arm = ($urandom_range(0, 19) == 0);
                step();
            end
            arm = 1'b0; trig = 1'b0; abort = 1'b0;
            wr_bus.wr_full = 1'b0;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        chk("drain", WW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
